// File: rtl/seg7_pkg.sv
// Shared types, blank glyph and hex-to-segment decode for the 7-segment scan driver.
package seg7_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] seg_t;   // {a,b,c,d,e,f,g}

   // All segments off in active-low encoding.
   localparam seg_t SEG_BLANK = 7'b111_1111;

   // Hex glyphs in active-low {a..g}; callers invert for active-high boards.
   function automatic seg_t hex_to_seg(input nibble_t nib);
      seg_t s;
      case (nib)
         4'h0:    s = 7'b000_0001;
         4'h1:    s = 7'b100_1111;
         4'h2:    s = 7'b001_0010;
         4'h3:    s = 7'b000_0110;
         4'h4:    s = 7'b100_1100;
         4'h5:    s = 7'b010_0100;
         4'h6:    s = 7'b010_0000;
         4'h7:    s = 7'b000_1111;
         4'h8:    s = 7'b000_0000;
         4'h9:    s = 7'b000_0100;
         4'hA:    s = 7'b000_1000;
         4'hB:    s = 7'b110_0000;
         4'hC:    s = 7'b011_0001;
         4'hD:    s = 7'b100_0010;
         4'hE:    s = 7'b011_0000;
         default: s = 7'b011_1000;   // F
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppression mask: marks digits that are zero along with every
// digit above them. Digit 0 is never suppressed so an all-zero value shows "0".
module seg7_lz_mask
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4
) (
   input  nibble_t [NUM_DIGITS-1:0] nibbles_i,
   input  logic                     lz_en_i,
   output logic    [NUM_DIGITS-1:0] suppress_o
);

   logic zero_run;

   // Walk from the most significant digit down while the run of zeros holds.
   always_comb begin
      zero_run   = lz_en_i;
      suppress_o = '0;
      for (int unsigned i = NUM_DIGITS; i > 1; i--) begin
         zero_run          = zero_run & (nibbles_i[i-1] == 4'h0);
         suppress_o[i-1]   = zero_run;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit 7-segment display with tear-free frame
// loading, per-digit blanking, decimal points, leading-zero suppression and an
// anti-ghost gap at the start of every digit slot.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SLOT_CYCLES    = 100000,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_en,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   import seg7_pkg::*;

   localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

   // Inactive output levels after polarity is applied.
   localparam seg_t                  SEG_OFF = SEG_ACTIVE_LOW ? SEG_BLANK : 7'b000_0000;
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

   // Scan counters
   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
   logic             slot_wrap;
   logic             frame_end;

   // Pending (load side) and display (scan side) frame registers
   nibble_t [NUM_DIGITS-1:0] pend_nib_q, pend_nib_d;
   logic    [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic    [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
   logic                     pend_lz_q, pend_lz_d;
   logic                     pend_valid_q, pend_valid_d;

   nibble_t [NUM_DIGITS-1:0] disp_nib_q, disp_nib_d;
   logic    [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic    [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
   logic                     disp_lz_q, disp_lz_d;

   // Output path
   logic    [NUM_DIGITS-1:0] suppress;
   logic    [NUM_DIGITS-1:0] an_onehot;
   nibble_t                  cur_nib;
   logic                     cur_dark;
   seg_t                     glyph;
   seg_t                     seg_q, seg_d;
   logic                     dp_q, dp_d;
   logic    [NUM_DIGITS-1:0] an_q, an_d;

   assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
   assign frame_end  = slot_wrap && (digit_idx_q == LAST_DIGIT);
   assign frame_tick = frame_end;

   // Slot counter advances every cycle; digit index steps when a slot wraps.
   always_comb begin
      slot_cnt_d  = slot_cnt_q + 1'b1;
      digit_idx_d = digit_idx_q;
      if (slot_wrap) begin
         slot_cnt_d  = '0;
         digit_idx_d = (digit_idx_q == LAST_DIGIT) ? '0 : digit_idx_q + 1'b1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q  <= '0;
         digit_idx_q <= '0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_idx_q <= digit_idx_d;
      end
   end

   // Promotion to display happens before the load capture so a load on the
   // boundary cycle lands in pending and waits for the following frame.
   always_comb begin
      pend_nib_d   = pend_nib_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_lz_d    = pend_lz_q;
      pend_valid_d = pend_valid_q;
      disp_nib_d   = disp_nib_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
      disp_lz_d    = disp_lz_q;
      if (frame_end && pend_valid_q) begin
         disp_nib_d   = pend_nib_q;
         disp_dp_d    = pend_dp_q;
         disp_blank_d = pend_blank_q;
         disp_lz_d    = pend_lz_q;
         pend_valid_d = 1'b0;
      end
      if (load) begin
         pend_nib_d   = digits_in;
         pend_dp_d    = dp_in;
         pend_blank_d = blank_in;
         pend_lz_d    = lz_en;
         pend_valid_d = 1'b1;
      end
   end

   // Pending and display frame registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_nib_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_lz_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         disp_nib_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
         disp_lz_q    <= 1'b0;
      end else begin
         pend_nib_q   <= pend_nib_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_lz_q    <= pend_lz_d;
         pend_valid_q <= pend_valid_d;
         disp_nib_q   <= disp_nib_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         disp_lz_q    <= disp_lz_d;
      end
   end

   seg7_lz_mask #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_lz_mask (
      .nibbles_i  (disp_nib_q),
      .lz_en_i    (disp_lz_q),
      .suppress_o (suppress)
   );

   // Select the current digit's glyph and anode, applying board polarity.
   always_comb begin
      cur_nib   = disp_nib_q[digit_idx_q];
      cur_dark  = disp_blank_q[digit_idx_q] | suppress[digit_idx_q];
      glyph     = cur_dark ? SEG_BLANK : hex_to_seg(cur_nib);
      seg_d     = SEG_ACTIVE_LOW ? glyph : ~glyph;
      dp_d      = SEG_ACTIVE_LOW ? ~disp_dp_q[digit_idx_q] : disp_dp_q[digit_idx_q];
      an_onehot = '0;
      if (slot_cnt_q >= GAP_END) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == digit_idx_q) begin
               an_onehot[i] = 1'b1;
            end
         end
      end
      an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
   end

   // Registered pin drivers; reset forces everything dark immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
         an_q  <= AN_OFF;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: two drivers (active-low pins and fully active-high pins) share
// stimulus; every output is compared cycle by cycle against hand-written frames.
module tb_seg7_scan_driver;

   localparam int unsigned SLOT = 8;
   localparam int unsigned GAP  = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in     = '0;
   logic [3:0]  blank_in  = '0;
   logic        lz_en     = 1'b0;
   logic        load      = 1'b0;

   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic [3:0]  an_a, an_b;
   logic        tick_a, tick_b;

   int n_vec  = 0;
   int n_miss = 0;

   // Active-low glyphs 0..F, transcribed from the display table.
   logic [6:0] seg_tbl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS     (4),
      .SLOT_CYCLES    (SLOT),
      .GAP_CYCLES     (GAP),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) u_dut_lo (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_en      (lz_en),
      .load       (load),
      .seg        (seg_a),
      .dp         (dp_a),
      .an         (an_a),
      .frame_tick (tick_a)
   );

   seg7_scan_driver #(
      .NUM_DIGITS     (4),
      .SLOT_CYCLES    (SLOT),
      .GAP_CYCLES     (GAP),
      .SEG_ACTIVE_LOW (1'b0),
      .AN_ACTIVE_LOW  (1'b0)
   ) u_dut_hi (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_en      (lz_en),
      .load       (load),
      .seg        (seg_b),
      .dp         (dp_b),
      .an         (an_b),
      .frame_tick (tick_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; holds the new frame on the inputs with a 1-cycle load.
   task automatic pulse_load(input logic [15:0] dg, input logic [3:0] dpv,
                             input logic [3:0] bl, input logic lz);
      digits_in = dg;
      dp_in     = dpv;
      blank_in  = bl;
      lz_en     = lz;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   // Checks one whole frame; the next negedge must show digit 0, slot 0.
   task automatic scan_frame(input string tag, input logic [15:0] nib,
                             input logic [3:0] dark, input logic [3:0] dpl);
      int         d;
      int         sl;
      logic [3:0] nb;
      logic [6:0] g, gb;
      logic       p, pb, t;
      logic [3:0] a, ab;
      for (int s = 0; s < 32; s++) begin
         @(negedge clk);
         d  = s / 8;
         sl = s % 8;
         nb = nib[d*4 +: 4];
         g  = dark[d] ? 7'b1111111 : seg_tbl[nb];
         p  = dpl[d] ? 1'b0 : 1'b1;
         a  = 4'b0001 << d;
         a  = (sl >= GAP) ? ~a : 4'b1111;
         t  = (s == 30);
         gb = ~g;
         pb = ~p;
         ab = ~a;
         chk($sformatf("%s[%0d].seg", tag, s),   seg_a,  g);
         chk($sformatf("%s[%0d].dp", tag, s),    dp_a,   p);
         chk($sformatf("%s[%0d].an", tag, s),    an_a,   a);
         chk($sformatf("%s[%0d].tick", tag, s),  tick_a, t);
         chk($sformatf("%s[%0d].segH", tag, s),  seg_b,  gb);
         chk($sformatf("%s[%0d].dpH", tag, s),   dp_b,   pb);
         chk($sformatf("%s[%0d].anH", tag, s),   an_b,   ab);
         chk($sformatf("%s[%0d].tickH", tag, s), tick_b, t);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.seg",   seg_a,  7'h7F);
      chk("rst.dp",    dp_a,   1'b1);
      chk("rst.an",    an_a,   4'hF);
      chk("rst.tick",  tick_a, 1'b0);
      chk("rst.segH",  seg_b,  7'h00);
      chk("rst.dpH",   dp_b,   1'b0);
      chk("rst.anH",   an_b,   4'h0);
      chk("rst.tickH", tick_b, 1'b0);
      rst_n = 1'b1;

      // Cleared display shows "0" everywhere while 1234 is loaded.
      fork
         scan_frame("f0_zero", 16'h0000, 4'b0000, 4'b0000);
         begin repeat (5) @(negedge clk); pulse_load(16'h1234, 4'h0, 4'h0, 1'b0); end
      join
      fork
         scan_frame("f1_1234", 16'h1234, 4'b0000, 4'b0000);
         begin repeat (3) @(negedge clk); pulse_load(16'h0050, 4'h0, 4'h0, 1'b1); end
      join
      fork
         scan_frame("f2_lz0050", 16'h0050, 4'b1100, 4'b0000);
         begin repeat (3) @(negedge clk); pulse_load(16'h0000, 4'h0, 4'h0, 1'b1); end
      join
      // Mid-frame load must not tear the frame in progress.
      fork
         scan_frame("f3_lz0000", 16'h0000, 4'b1110, 4'b0000);
         begin repeat (12) @(negedge clk); pulse_load(16'hABCD, 4'h0, 4'h0, 1'b0); end
      join
      fork
         scan_frame("f4_ABCD", 16'hABCD, 4'b0000, 4'b0000);
         begin
            repeat (5) @(negedge clk);  pulse_load(16'h1111, 4'h0, 4'h0, 1'b0);
            repeat (14) @(negedge clk); pulse_load(16'h2222, 4'h0, 4'h0, 1'b0);
         end
      join
      fork
         scan_frame("f5_2222", 16'h2222, 4'b0000, 4'b0000);
         begin repeat (2) @(negedge clk); pulse_load(16'h1234, 4'b0100, 4'b0010, 1'b0); end
      join
      fork
         scan_frame("f6_blank_dp", 16'h1234, 4'b0010, 4'b0100);
         begin repeat (2) @(negedge clk); pulse_load(16'h3210, 4'h0, 4'h0, 1'b0); end
      join
      // Glyph sweep across all sixteen nibbles.
      fork
         scan_frame("f7_3210", 16'h3210, 4'b0000, 4'b0000);
         begin repeat (2) @(negedge clk); pulse_load(16'h7654, 4'h0, 4'h0, 1'b0); end
      join
      fork
         scan_frame("f8_7654", 16'h7654, 4'b0000, 4'b0000);
         begin repeat (2) @(negedge clk); pulse_load(16'hBA98, 4'h0, 4'h0, 1'b0); end
      join
      fork
         scan_frame("f9_BA98", 16'hBA98, 4'b0000, 4'b0000);
         begin repeat (2) @(negedge clk); pulse_load(16'hFEDC, 4'h0, 4'h0, 1'b0); end
      join
      scan_frame("f10_FEDC", 16'hFEDC, 4'b0000, 4'b0000);

      // Mid-slot reset with data still pending.
      repeat (3) @(negedge clk);
      pulse_load(16'h9999, 4'hF, 4'h0, 1'b0);
      repeat (4) @(negedge clk);
      chk("pre_rst.an",  an_a,  4'b1110);
      chk("pre_rst.seg", seg_a, 7'b0110001);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst.seg",   seg_a,  7'h7F);
      chk("mid_rst.dp",    dp_a,   1'b1);
      chk("mid_rst.an",    an_a,   4'hF);
      chk("mid_rst.tick",  tick_a, 1'b0);
      chk("mid_rst.segH",  seg_b,  7'h00);
      chk("mid_rst.anH",   an_b,   4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      scan_frame("f11_after_rst", 16'h0000, 4'b0000, 4'b0000);
      scan_frame("f12_pend_lost", 16'h0000, 4'b0000, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
